// File: rtl/led_pkg.sv
// Shared definitions for the multi-channel LED driver: channel modes and
// the width of the channel index on the configuration port.
package led_pkg;

  localparam int CH_IDX_W = 4;

  typedef enum logic [1:0] {
    MODE_OFF     = 2'b00,
    MODE_ON      = 2'b01,
    MODE_BLINK   = 2'b10,
    MODE_ONESHOT = 2'b11
  } led_mode_e;

endpackage

// File: rtl/led_prescaler.sv
// Free-running timebase: counts 0..DIV-1 and flags the last count as a
// one-cycle tick. A sync strobe restarts the count and suppresses the tick
// of that cycle so every consumer sees a fresh, full period afterwards.
module led_prescaler #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int TICK_HZ  = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sync,
  output logic tick
);

  localparam int DIV   = CLK_FREQ / TICK_HZ;
  localparam int CNT_W = $clog2(DIV);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q;

  // Prescaler count: wrap at DIV-1, restart on sync.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (sync || (cnt_q == LAST)) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign tick = (cnt_q == LAST) && !sync;

endmodule

// File: rtl/led_ctrl_multi.sv
// Multi-channel LED driver. One shared prescaler produces the tick; each
// channel holds its own mode, half-period and tick counter.
//
// Config port: cfg_we is a single-cycle strobe sampled on the rising edge;
// there is no ready, so a write always lands on the edge it is presented.
// A write to an index >= N_CH matches no channel and is dropped.
// Priority inside a channel: own write > cfg_sync > tick.
module led_ctrl_multi
  import led_pkg::*;
#(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int TICK_HZ   = 1000,
  parameter int N_CH      = 4,
  parameter int HALF_W    = 16,
  parameter int INIT_HALF = 1000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_we,
  input  logic [CH_IDX_W-1:0] cfg_ch,
  input  logic [1:0]          cfg_mode,
  input  logic [HALF_W-1:0]   cfg_half,
  input  logic                cfg_sync,
  output logic [N_CH-1:0]     led,
  output logic [N_CH-1:0]     busy,
  output logic                tick_o
);

  localparam logic [HALF_W-1:0] INIT_HALF_V = HALF_W'(INIT_HALF);

  logic tick;

  led_prescaler #(
    .CLK_FREQ (CLK_FREQ),
    .TICK_HZ  (TICK_HZ)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .sync  (cfg_sync),
    .tick  (tick)
  );

  assign tick_o = tick;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    led_mode_e         mode_q, mode_d;
    logic [HALF_W-1:0] half_q, half_d;
    logic [HALF_W-1:0] cnt_q, cnt_d;
    logic [HALF_W-1:0] h_m1;
    logic              led_q, led_d;
    logic              busy_q, busy_d;
    logic              wr_hit;

    assign wr_hit = cfg_we && (cfg_ch == CH_IDX_W'(g));
    // A half-period of 0 behaves as 1, so the terminal count never underflows.
    assign h_m1   = (half_q == '0) ? '0 : half_q - HALF_W'(1);

    // Channel next state: write, then sync, then tick; otherwise hold.
    always_comb begin
      mode_d = mode_q;
      half_d = half_q;
      cnt_d  = cnt_q;
      led_d  = led_q;
      busy_d = busy_q;
      if (wr_hit) begin
        mode_d = led_mode_e'(cfg_mode);
        half_d = cfg_half;
        cnt_d  = '0;
        led_d  = (cfg_mode == MODE_ON) || (cfg_mode == MODE_ONESHOT);
        busy_d = (cfg_mode == MODE_ONESHOT);
      end else if (cfg_sync) begin
        // ONESHOT keeps led/busy high and simply restarts its count.
        cnt_d = '0;
        if (mode_q == MODE_BLINK) begin
          led_d = 1'b0;
        end
      end else if (tick) begin
        case (mode_q)
          MODE_OFF: begin
            led_d = 1'b0;
            cnt_d = '0;
          end
          MODE_ON: begin
            led_d = 1'b1;
            cnt_d = '0;
          end
          MODE_BLINK: begin
            if (cnt_q == h_m1) begin
              cnt_d = '0;
              led_d = ~led_q;
            end else begin
              cnt_d = cnt_q + HALF_W'(1);
            end
          end
          MODE_ONESHOT: begin
            if (cnt_q == h_m1) begin
              cnt_d  = '0;
              led_d  = 1'b0;
              busy_d = 1'b0;
              mode_d = MODE_OFF;
            end else begin
              cnt_d = cnt_q + HALF_W'(1);
            end
          end
          default: begin
            cnt_d = '0;
          end
        endcase
      end
    end

    // Channel state register; reset reproduces the legacy blinker.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        mode_q <= MODE_BLINK;
        half_q <= INIT_HALF_V;
        cnt_q  <= '0;
        led_q  <= 1'b0;
        busy_q <= 1'b0;
      end else begin
        mode_q <= mode_d;
        half_q <= half_d;
        cnt_q  <= cnt_d;
        led_q  <= led_d;
        busy_q <= busy_d;
      end
    end

    assign led[g]  = led_q;
    assign busy[g] = busy_q;
  end

endmodule
